// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush control for load-use hazards, taken branches and multi-cycle MDU ops.
module hazard_control_unit #(
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_if_id,
  input  logic [4:0]       rs2_if_id,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [4:0]       rd_id_ex,
  input  logic             mem_read_id_ex,
  input  logic             branch_taken_ex,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_hold,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state_q;
  logic [7:0] busy_cnt_q;
  logic       timeout_now;
  logic       lu;
  always_comb begin
    timeout_now = (state_q == BUSY) && !mdu_done && (busy_cnt_q == 8'(MDU_TIMEOUT - 1));
    ex_hold     = (state_q == IDLE) ? (mdu_start && !mdu_done) : (!mdu_done && !timeout_now);
    lu          = mem_read_id_ex && (rd_id_ex != 5'd0) &&
                  ((use_rs1 && rs1_if_id == rd_id_ex) || (use_rs2 && rs2_if_id == rd_id_ex));
    pc_write    = !ex_hold && (branch_taken_ex || !lu);
    if_id_write = pc_write;
    if_id_flush = !ex_hold && branch_taken_ex;
    id_ex_flush = !ex_hold && (branch_taken_ex || lu);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_cnt_q  <= 8'd0;
      mdu_timeout <= 1'b0;
    end else if (state_q == IDLE) begin
      if (mdu_start && !mdu_done) begin
        state_q    <= BUSY;
        busy_cnt_q <= 8'd0;
      end
    end else if (mdu_done) begin
      state_q <= IDLE;
    end else if (timeout_now) begin
      state_q     <= IDLE;
      mdu_timeout <= 1'b1;
    end else begin
      busy_cnt_q <= busy_cnt_q + 8'd1;
    end
  end
  // performance counters saturate at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
      if (if_id_flush && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter MDU_TIMEOUT, default 64: maximum cycles spent in BUSY before forced abort; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rs1_if_id  input  5  source register 1 of the instruction in IF/ID.
REQ-006 rs2_if_id  input  5  source register 2 of the instruction in IF/ID.
REQ-007 use_rs1 / use_rs2  input  1 each  the IF/ID instruction actually reads rs1 / rs2.
REQ-008 rd_id_ex  input  5  destination register of the instruction in ID/EX.
REQ-009 mem_read_id_ex  input  1  the ID/EX instruction is a load.
REQ-010 branch_taken_ex  input  1  the EX-stage branch or jump resolved taken this cycle.
REQ-011 mdu_start  input  1  the ID/EX instruction is a multi-cycle mul/div and is entering EX this cycle.
REQ-012 mdu_done  input  1  the multi-cycle unit result is valid this cycle.
REQ-013 pc_write  output  1  PC update enable.
REQ-014 if_id_write  output  1  IF/ID register load enable.
REQ-015 if_id_flush  output  1  IF/ID register is cleared to a NOP.
REQ-016 id_ex_flush  output  1  ID/EX register loads a bubble.
REQ-017 ex_hold  output  1  ID/EX and EX stage hold; EX/MEM loads a bubble.
REQ-018 mdu_timeout  output  1  sticky error flag.
REQ-019 stall_count  output  CNT_W  count of front-end stall cycles.
REQ-020 flush_count  output  CNT_W  count of flush cycles.

Function
REQ-021 The FSM SHALL have exactly two states, IDLE and BUSY; BUSY is entered from IDLE on mdu_start=1 with mdu_done=0.
REQ-022 BUSY SHALL return to IDLE on mdu_done=1, or after MDU_TIMEOUT consecutive BUSY cycles without mdu_done, in which case mdu_timeout is set to 1 and held until reset.
REQ-023 A BUSY-cycle counter SHALL clear on entry to BUSY and SHALL increment each BUSY cycle.
REQ-024 An mdu_start with mdu_done=1 in the same IDLE cycle is a single-cycle op: no hold, the FSM stays in IDLE.
REQ-025 ex_hold SHALL be 1 when (IDLE and mdu_start and !mdu_done) or (BUSY and !mdu_done and no timeout this cycle), combinationally.
REQ-026 Load-use hazard lu SHALL be 1 when mem_read_id_ex=1, rd_id_ex!=0, and rd_id_ex matches (rs1_if_id with use_rs1) or (rs2_if_id with use_rs2).
REQ-027 Priority SHALL be: ex_hold, then branch_taken_ex, then lu; mdu_start and branch_taken_ex are never both 1, because the MDU op is in EX.
REQ-028 When ex_hold=1: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=0; branch_taken_ex and lu are ignored.
REQ-029 Else when branch_taken_ex=1: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1 (a pending lu is discarded with the flushed instruction).
REQ-030 Else when lu=1: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0, lasting exactly one cycle per hazard.
REQ-031 Otherwise: pc_write=1, if_id_write=1, both flushes 0.
REQ-032 All control outputs (pc_write, if_id_write, if_id_flush, id_ex_flush, ex_hold) SHALL be combinational in the same cycle as their inputs; the counters and mdu_timeout SHALL be registered.
REQ-033 stall_count SHALL increment on each clock edge where pc_write=0.
REQ-034 flush_count SHALL increment on each clock edge where if_id_flush=1.
REQ-035 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-036 rst_n=0 SHALL asynchronously force state IDLE, BUSY counter 0, mdu_timeout 0, stall_count 0, flush_count 0; reset mid-BUSY aborts with no timeout flag.
REQ-037 During reset, control outputs SHALL evaluate as in IDLE (pc_write=1, if_id_write=1, flushes 0, ex_hold=0 for idle inputs).

Verification
REQ-038 Load x5, then a dependent add (rs1=5, use_rs1=1) -> one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; stall_count=1.
REQ-039 Load with rd=0 and a dependent use of x0 -> no stall; same hazard with use_rs1=0 -> no stall.
REQ-040 branch_taken_ex=1 together with lu=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count +1, stall_count unchanged.
REQ-041 mdu_start, then mdu_done 5 cycles later -> ex_hold=1 for exactly 5 cycles, stall_count +5, FSM in IDLE afterwards.
REQ-042 mdu_start with mdu_done never asserted, MDU_TIMEOUT=8 -> ex_hold drops after the 8th BUSY cycle, mdu_timeout=1 sticky; rst_n low clears it.
REQ-043 Preload stall_count near all-ones via forced stalls (CNT_W=4) -> holds at 15, no wrap.
